// File: rtl/byte_queue.sv
// Circular byte FIFO behind the serial-to-byte deserializer: level-held enqueue
// with one-shot ack, edge-triggered dequeue, occupancy and sticky overflow status.
module byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clock_10KHz,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       enqueue_in,
  output logic                       enq_ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH):0]     len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             arm;
  logic             deq_prev;

  logic             is_full;
  logic             is_empty;
  logic             enq_req;
  logic             deq_fire;
  logic             enq_fire;

  // Handshake: the producer holds enqueue_in high with data_in stable until it
  // sees enq_ack_out; the word is written at the edge before the ack pulse and
  // a new word is only taken after enqueue_in has been low for one edge.
  // A full queue still accepts when a dequeue frees the slot at the same edge.
  always_comb begin
    is_full  = (count == LW'(DEPTH));
    is_empty = (count == '0);
    enq_req  = enqueue_in && arm;
    deq_fire = dequeue_in && !deq_prev && !is_empty;
    enq_fire = enq_req && (!is_full || deq_fire);
  end

  assign len_out   = count;
  assign full_out  = is_full;
  assign empty_out = is_empty;

  always_ff @(posedge clock_10KHz) begin
    if (enq_fire) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock_10KHz) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      arm          <= 1'b1;
      deq_prev     <= 1'b0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      enq_ack_out  <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      deq_prev    <= dequeue_in;
      enq_ack_out <= enq_fire;
      valid_out   <= deq_fire;

      if (enq_fire) begin
        wr_ptr <= wr_ptr + PW'(1);
        arm    <= 1'b0;
      end else if (!enqueue_in) begin
        arm <= 1'b1;
      end

      if (enq_req && is_full && !deq_fire) overflow_out <= 1'b1;

      if (deq_fire) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end

      if (enq_fire && !deq_fire)      count <= count + LW'(1);
      else if (deq_fire && !enq_fire) count <= count - LW'(1);
    end
  end

endmodule

// File: tb/tb_byte_queue.sv
// Directed self-checking bench for byte_queue: reset, handshake, full/overflow,
// wrap-around, simultaneous enqueue/dequeue and mid-handshake reset.
`timescale 1ns/1ps
module tb_byte_queue;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       enq_ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;
  logic       overflow_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int val_cnt = 0;
  int ack_base;
  int val_base;

  byte_queue #(.DEPTH(8), .WIDTH(8)) dut (
    .clock_10KHz (clk),
    .rst         (rst),
    .data_in     (data_in),
    .enqueue_in  (enqueue_in),
    .enq_ack_out (enq_ack_out),
    .dequeue_in  (dequeue_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .len_out     (len_out),
    .full_out    (full_out),
    .empty_out   (empty_out),
    .overflow_out(overflow_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && enq_ack_out) ack_cnt++;
    if (!rst && valid_out)   val_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: hold request until ack, then release for one edge to re-arm
  task automatic enq(input logic [7:0] b);
    bit seen;
    seen = 0;
    data_in    = b;
    enqueue_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (enq_ack_out) begin
        seen = 1;
        break;
      end
    end
    chk("enq_ack_seen", {31'd0, seen}, 32'd1);
    enqueue_in = 1'b0;
    tick();
  endtask

  task automatic deq(input logic [7:0] exp);
    dequeue_in = 1'b1;
    tick();
    chk("deq_valid", {31'd0, valid_out}, 32'd1);
    chk("deq_data", {24'd0, data_out}, {24'd0, exp});
    dequeue_in = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; data_in = 8'h00; enqueue_in = 1'b0; dequeue_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ack_base = ack_cnt; val_base = val_cnt;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_empty", {31'd0, empty_out}, 32'd1);
    chk("rst_full", {31'd0, full_out}, 32'd0);
    chk("rst_len", {28'd0, len_out}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
    chk("rst_no_pulses", ack_cnt - ack_base + val_cnt - val_base, 32'd0);

    // single word, request held for 4 cycles
    ack_base = ack_cnt;
    data_in = 8'hA5; enqueue_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    enqueue_in = 1'b0;
    tick();
    chk("hold_one_ack", ack_cnt - ack_base, 32'd1);
    chk("hold_len", {28'd0, len_out}, 32'd1);
    deq(8'hA5);
    chk("a5_empty", {31'd0, empty_out}, 32'd1);
    chk("a5_valid_drop", {31'd0, valid_out}, 32'd0);

    // fill, then overflow attempt
    for (int i = 1; i <= 8; i++) enq(8'(i));
    chk("fill_full", {31'd0, full_out}, 32'd1);
    chk("fill_len", {28'd0, len_out}, 32'd8);
    ack_base = ack_cnt;
    data_in = 8'h09; enqueue_in = 1'b1;
    tick(); tick(); tick();
    chk("ovf_flag", {31'd0, overflow_out}, 32'd1);
    chk("ovf_no_ack", ack_cnt - ack_base, 32'd0);
    chk("ovf_len", {28'd0, len_out}, 32'd8);
    dequeue_in = 1'b1;
    tick();
    chk("retry_data", {24'd0, data_out}, 32'h01);
    chk("retry_valid", {31'd0, valid_out}, 32'd1);
    chk("retry_ack", {31'd0, enq_ack_out}, 32'd1);
    chk("retry_len", {28'd0, len_out}, 32'd8);
    chk("retry_full", {31'd0, full_out}, 32'd1);
    enqueue_in = 1'b0; dequeue_in = 1'b0;
    tick();
    for (int i = 2; i <= 9; i++) deq(8'(i));
    chk("drain_empty", {31'd0, empty_out}, 32'd1);

    // wrap-around
    for (int i = 0; i < 6; i++) enq(8'h20 + 8'(i));
    for (int i = 0; i < 6; i++) deq(8'h20 + 8'(i));
    for (int i = 0; i < 6; i++) enq(8'h10 + 8'(i));
    chk("wrap_len6", {28'd0, len_out}, 32'd6);
    for (int i = 0; i < 6; i++) deq(8'h10 + 8'(i));
    chk("wrap_len0", {28'd0, len_out}, 32'd0);

    // simultaneous at len 3
    enq(8'h30); enq(8'h31); enq(8'h32);
    data_in = 8'h33; enqueue_in = 1'b1; dequeue_in = 1'b1;
    tick();
    chk("sim3_len", {28'd0, len_out}, 32'd3);
    chk("sim3_data", {24'd0, data_out}, 32'h30);
    chk("sim3_valid", {31'd0, valid_out}, 32'd1);
    chk("sim3_ack", {31'd0, enq_ack_out}, 32'd1);
    enqueue_in = 1'b0; dequeue_in = 1'b0;
    tick();
    deq(8'h31); deq(8'h32); deq(8'h33);

    // simultaneous at len 0: dequeue dropped
    data_in = 8'h44; enqueue_in = 1'b1; dequeue_in = 1'b1;
    tick();
    chk("sim0_len", {28'd0, len_out}, 32'd1);
    chk("sim0_valid", {31'd0, valid_out}, 32'd0);
    chk("sim0_ack", {31'd0, enq_ack_out}, 32'd1);
    chk("sim0_data_hold", {24'd0, data_out}, 32'h33);
    enqueue_in = 1'b0; dequeue_in = 1'b0;
    tick();

    // reset mid-handshake with 4 words queued
    enq(8'h45); enq(8'h46); enq(8'h47);
    chk("pre_rst_len", {28'd0, len_out}, 32'd4);
    ack_base = ack_cnt;
    data_in = 8'h50; enqueue_in = 1'b1; rst = 1'b1;
    tick();
    chk("mid_rst_ack", {31'd0, enq_ack_out}, 32'd0);
    chk("mid_rst_len", {28'd0, len_out}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty_out}, 32'd1);
    chk("mid_rst_full", {31'd0, full_out}, 32'd0);
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow_out}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    tick();
    rst = 1'b0; enqueue_in = 1'b0;
    tick(); tick();
    chk("post_rst_no_ack", ack_cnt - ack_base, 32'd0);
    chk("post_rst_len", {28'd0, len_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
